// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet transmit stream arbiter.
// Holds the arbiter state encoding and a channel-count-generic round-robin picker.
package eth_tx_arb_pkg;

  // Arbiter FSM states; DROP is only ever entered when ETH_TX_ARB_MAXLEN_EN is defined
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } arbState_e;

  // Upper bound on channels the round-robin helper can search
  localparam int RR_MAX_CH = 64;

  // Returns the first requesting channel after ptr (wrapping modulo numCh).
  // Callers only use the result when at least one request is present.
  function automatic int rrNextGrant(input logic [RR_MAX_CH-1:0] req,
                                     input int numCh,
                                     input int ptr);
    logic found;
    int   idx;
    int   pick;
    found = 1'b0;
    pick  = 0;
    idx   = 0;
    for (int k = 1; k <= RR_MAX_CH; k++) begin
      if (k <= numCh) begin
        idx = (ptr + k) % numCh;
        if (!found && req[idx[5:0]]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: registered output plus one skid entry,
// giving full throughput while fully decoupling the upstream ready path.
module axis_skid_buf #(
  parameter int WIDTH = 35
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inValid_i,
  output logic             inReady_o,
  input  logic [WIDTH-1:0] inData_i,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic [WIDTH-1:0] outData_o
);

  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic             skidValid_q;
  logic [WIDTH-1:0] skidData_q;
  logic             push;
  logic             pop;

  // Upstream may only push while the skid entry is empty, i.e. the slice is not full
  assign inReady_o  = !skidValid_q;
  assign push       = inValid_i && !skidValid_q;
  assign pop        = outValid_q && outReady_i;
  assign outValid_o = outValid_q;
  assign outData_o  = outData_q;

  // Output entry refills from the skid entry first so beat order is preserved
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else if (skidValid_q) begin
      if (pop) begin
        outData_q   <= skidData_q;
        skidValid_q <= 1'b0;
      end
    end else if (push) begin
      if (!outValid_q || pop) begin
        outValid_q <= 1'b1;
        outData_q  <= inData_i;
      end else begin
        skidValid_q <= 1'b1;
        skidData_q  <= inData_i;
      end
    end else if (pop) begin
      outValid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_tx_stream_arb.sv
// Frame-level round-robin arbiter merging NUM_CH AXI-Stream sources onto one
// stream with source id and a registered skid output stage.
// Optional max-frame-length truncation: define ETH_TX_ARB_MAXLEN_EN.
module eth_tx_stream_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 512,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [CH_W-1:0]          m_axis_tid,
  input  logic                     m_axis_tready,
  output logic                     trunc_pulse
);

  localparam int SKID_W = DATA_W + CH_W + 1;

  arbState_e              state_q, state_d;
  logic [CH_W-1:0]        grant_q, grant_d;
  logic [CH_W-1:0]        rrPtr_q, rrPtr_d;
  logic [RR_MAX_CH-1:0]   reqExt;
  logic                   grantValid;
  logic                   grantLast;
  logic [DATA_W-1:0]      grantData;
  logic                   lastOut;
  logic                   skidInValid;
  logic                   skidInReady;
  logic [SKID_W-1:0]      skidInData;
  logic [SKID_W-1:0]      skidOutData;

`ifdef ETH_TX_ARB_MAXLEN_EN
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic             trunc_q, trunc_d;
`endif

  // Widen the request vector to the helper's fixed search width
  always_comb begin
    reqExt = '0;
    reqExt[NUM_CH-1:0] = s_axis_tvalid;
  end

  assign grantValid = s_axis_tvalid[grant_q];
  assign grantLast  = s_axis_tlast[grant_q];
  assign grantData  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
  assign skidInData = {grant_q, lastOut, grantData};

  // Arbitration, forwarding handshake and optional truncation decisions
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rrPtr_d       = rrPtr_q;
    s_axis_tready = '0;
    skidInValid   = 1'b0;
    lastOut       = grantLast;
`ifdef ETH_TX_ARB_MAXLEN_EN
    beatCnt_d     = beatCnt_q;
    trunc_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = CH_W'(rrNextGrant(reqExt, NUM_CH, int'(rrPtr_q)));
          rrPtr_d = CH_W'(rrNextGrant(reqExt, NUM_CH, int'(rrPtr_q)));
          state_d = FWD;
`ifdef ETH_TX_ARB_MAXLEN_EN
          beatCnt_d = '0;
`endif
        end
      end
      FWD: begin
        s_axis_tready[grant_q] = skidInReady;
        skidInValid            = grantValid;
        if (grantValid && skidInReady) begin
`ifdef ETH_TX_ARB_MAXLEN_EN
          beatCnt_d = beatCnt_q + CNT_W'(1);
          if (grantLast) begin
            state_d = IDLE;
          end else if (beatCnt_q == CNT_W'(MAX_WORDS - 1)) begin
            lastOut = 1'b1;
            trunc_d = 1'b1;
            state_d = DROP;
          end
`else
          if (grantLast) begin
            state_d = IDLE;
          end
`endif
        end
      end
      DROP: begin
`ifdef ETH_TX_ARB_MAXLEN_EN
        s_axis_tready[grant_q] = 1'b1;
        if (grantValid && grantLast) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer; pointer resets to the last channel so ch0 wins first
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rrPtr_q <= CH_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
    end
  end

`ifdef ETH_TX_ARB_MAXLEN_EN
  // Beat counter and truncation pulse, registered to line up with the forced-tlast beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beatCnt_q <= '0;
      trunc_q   <= 1'b0;
    end else begin
      beatCnt_q <= beatCnt_d;
      trunc_q   <= trunc_d;
    end
  end
  assign trunc_pulse = trunc_q;
`else
  assign trunc_pulse = 1'b0;
`endif

  axis_skid_buf #(
    .WIDTH(SKID_W)
  ) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .inValid_i (skidInValid),
    .inReady_o (skidInReady),
    .inData_i  (skidInData),
    .outValid_o(m_axis_tvalid),
    .outReady_i(m_axis_tready),
    .outData_o (skidOutData)
  );

  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = skidOutData;

endmodule

// File: tb/tb_eth_tx_stream_arb.sv
// Directed testbench for eth_tx_stream_arb (truncation test runs when ETH_TX_ARB_MAXLEN_EN is defined).
module tb_eth_tx_stream_arb;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 8;
  localparam int CH_W      = 2;
  localparam int BUF       = 300;

  logic                     aclk;
  logic                     aresetn;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic [CH_W-1:0]          m_axis_tid;
  logic                     m_axis_tready;
  logic                     trunc_pulse;

  eth_tx_stream_arb #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tready(m_axis_tready), .trunc_pulse(trunc_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total;
  int bad;
  int cyc;

  logic [DATA_W-1:0] srcData [NUM_CH][BUF];
  logic              srcLast [NUM_CH][BUF];
  int                srcLen  [NUM_CH];
  int                srcPos  [NUM_CH];
  int                srcHoldPos [NUM_CH];
  int                srcHoldCnt [NUM_CH];

  logic [DATA_W-1:0] outData [BUF];
  logic              outLast [BUF];
  logic [CH_W-1:0]   outTid  [BUF];
  int                outCycle[BUF];
  int                outCnt;

  int          truncCnt;
  logic        readyRandom;
  logic [NUM_CH-1:0] accepted;
  logic        prevStall;
  logic [DATA_W-1:0] prevData;
  logic        prevLast;
  logic [CH_W-1:0] prevTid;
  logic        watchCh2;
  logic        ch1Done;
  int          ch2EarlyCnt;

  // Empty all source queues and output capture
  task automatic clearState();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      srcLen[ch] = 0;
      srcPos[ch] = 0;
      srcHoldPos[ch] = -1;
      srcHoldCnt[ch] = 0;
    end
    outCnt = 0;
    truncCnt = 0;
    prevStall = 1'b0;
    watchCh2 = 1'b0;
    ch1Done = 1'b0;
    ch2EarlyCnt = 0;
    readyRandom = 1'b0;
  endtask

  // Append one frame of n beats to a channel's source queue
  task automatic loadFrame(input int ch, input int n, input logic [DATA_W-1:0] base, input bit rnd);
    for (int k = 0; k < n; k++) begin
      srcData[ch][srcLen[ch]+k] = rnd ? DATA_W'($urandom) : base + DATA_W'(k);
      srcLast[ch][srcLen[ch]+k] = (k == n - 1);
    end
    srcLen[ch] = srcLen[ch] + n;
  endtask

  // Present the current beat of each source and the downstream ready
  task automatic applyStimulus();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (srcPos[ch] < srcLen[ch] && srcPos[ch] == srcHoldPos[ch] && srcHoldCnt[ch] > 0) begin
        srcHoldCnt[ch] = srcHoldCnt[ch] - 1;
        s_axis_tvalid[ch] = 1'b0;
        s_axis_tlast[ch] = 1'b0;
        s_axis_tdata[ch*DATA_W +: DATA_W] = '0;
      end else if (srcPos[ch] < srcLen[ch]) begin
        s_axis_tvalid[ch] = 1'b1;
        s_axis_tlast[ch] = srcLast[ch][srcPos[ch]];
        s_axis_tdata[ch*DATA_W +: DATA_W] = srcData[ch][srcPos[ch]];
      end else begin
        s_axis_tvalid[ch] = 1'b0;
        s_axis_tlast[ch] = 1'b0;
        s_axis_tdata[ch*DATA_W +: DATA_W] = '0;
      end
    end
    m_axis_tready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: drive, sample at negedge (stall stability, capture), advance sources
  task automatic runCycle();
    applyStimulus();
    @(negedge aclk);
    if (prevStall) begin
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prevData || m_axis_tlast !== prevLast || m_axis_tid !== prevTid) begin
        bad++;
        $display("[TB] FAIL stall_hold: got v=%b d=%h l=%b id=%0d, want v=1 d=%h l=%b id=%0d",
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid, prevData, prevLast, prevTid);
      end
    end
    prevStall = m_axis_tvalid && !m_axis_tready;
    prevData = m_axis_tdata;
    prevLast = m_axis_tlast;
    prevTid = m_axis_tid;
    if (m_axis_tvalid && m_axis_tready) begin
      if (outCnt < BUF) begin
        outData[outCnt] = m_axis_tdata;
        outLast[outCnt] = m_axis_tlast;
        outTid[outCnt] = m_axis_tid;
        outCycle[outCnt] = cyc;
      end
      outCnt++;
    end
    if (trunc_pulse === 1'b1) truncCnt++;
    if (watchCh2 && s_axis_tready[2] && !ch1Done) ch2EarlyCnt++;
    accepted = s_axis_tvalid & s_axis_tready;
    @(posedge aclk);
    cyc++;
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (accepted[ch]) begin
        if (ch == 1 && srcLast[1][srcPos[1]]) ch1Done = 1'b1;
        srcPos[ch] = srcPos[ch] + 1;
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  // Run until n output beats were seen, bounded by a cycle budget
  task automatic runUntil(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (outCnt < n && k < limit) begin
      runCycle();
      k++;
    end
    total++;
    if (outCnt < n) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d beats, want %0d", name, outCnt, n);
    end
  endtask

  // Hold reset for two clocks then release just after a rising edge
  task automatic applyReset();
    aresetn = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    clearState();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axis_tdata = '1;
    s_axis_tvalid = 4'b0010;
    s_axis_tlast = '0;
    m_axis_tready = 1'b1;
    clearState();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    total += 6;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    if (m_axis_tdata !== '0) begin bad++; $display("[TB] FAIL rst_tdata: got %h want 0", m_axis_tdata); end
    if (m_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    if (m_axis_tid !== '0) begin bad++; $display("[TB] FAIL rst_tid: got %0d want 0", m_axis_tid); end
    if (s_axis_tready !== '0) begin bad++; $display("[TB] FAIL rst_s_tready: got %b want 0000", s_axis_tready); end
    if (trunc_pulse !== 1'b0) begin bad++; $display("[TB] FAIL rst_trunc: got %b want 0", trunc_pulse); end
    applyReset();
  endtask

  task automatic test_single_frame();
    int startCyc;
    applyReset();
    loadFrame(0, 4, 32'hA000_0000, 0);
    startCyc = cyc;
    runUntil(4, 20, "single");
    runCycles(4);
    total++;
    if (outCnt != 4) begin bad++; $display("[TB] FAIL single_count: got %0d want 4", outCnt); end
    for (int k = 0; k < 4 && k < outCnt; k++) begin
      total++;
      if (outData[k] !== 32'hA000_0000 + k || outTid[k] !== 2'd0 || outLast[k] !== (k == 3) || outCycle[k] != startCyc + 2 + k) begin
        bad++;
        $display("[TB] FAIL single_beat%0d: got d=%h id=%0d l=%b cyc=%0d, want d=%h id=0 l=%b cyc=%0d",
                 k, outData[k], outTid[k], outLast[k], outCycle[k] - startCyc, 32'hA000_0000 + k, (k == 3), 2 + k);
      end
    end
  endtask

  task automatic test_all_channels();
    logic [DATA_W-1:0] expData;
    applyReset();
    for (int ch = 0; ch < NUM_CH; ch++) loadFrame(ch, 3, 32'hC000_0000 + ch * 32'h100, 0);
    runUntil(12, 60, "allch");
    runCycles(4);
    total += 2;
    if (outCnt != 12) begin bad++; $display("[TB] FAIL allch_count: got %0d want 12", outCnt); end
    if (truncCnt != 0) begin bad++; $display("[TB] FAIL allch_trunc: got %0d pulses want 0", truncCnt); end
    for (int j = 0; j < 12 && j < outCnt; j++) begin
      expData = 32'hC000_0000 + (j / 3) * 32'h100 + (j % 3);
      total++;
      if (outData[j] !== expData || outTid[j] !== CH_W'(j / 3) || outLast[j] !== ((j % 3) == 2)) begin
        bad++;
        $display("[TB] FAIL allch_beat%0d: got d=%h id=%0d l=%b, want d=%h id=%0d l=%b",
                 j, outData[j], outTid[j], outLast[j], expData, j / 3, ((j % 3) == 2));
      end
      if (j > 0) begin
        total++;
        if (outCycle[j] - outCycle[j-1] != (((j % 3) == 0) ? 2 : 1)) begin
          bad++;
          $display("[TB] FAIL allch_gap%0d: got %0d want %0d", j, outCycle[j] - outCycle[j-1], (((j % 3) == 0) ? 2 : 1));
        end
      end
    end
  endtask

  task automatic test_random_stall();
    applyReset();
    readyRandom = 1'b1;
    loadFrame(2, 256, '0, 1);
    runUntil(256, 3000, "stall");
    runCycles(8);
    total++;
    if (outCnt != 256) begin bad++; $display("[TB] FAIL stall_count: got %0d want 256", outCnt); end
    for (int k = 0; k < 256 && k < outCnt; k++) begin
      total++;
      if (outData[k] !== srcData[2][k] || outTid[k] !== 2'd2 || outLast[k] !== (k == 255)) begin
        bad++;
        $display("[TB] FAIL stall_beat%0d: got d=%h id=%0d l=%b, want d=%h id=2 l=%b",
                 k, outData[k], outTid[k], outLast[k], srcData[2][k], (k == 255));
      end
    end
    readyRandom = 1'b0;
  endtask

  task automatic test_hold_grant();
    logic [DATA_W-1:0] expData;
    applyReset();
    srcHoldPos[1] = 3;
    srcHoldCnt[1] = 5;
    watchCh2 = 1'b1;
    loadFrame(1, 8, 32'h1100_0000, 0);
    loadFrame(2, 3, 32'h2200_0000, 0);
    runUntil(11, 80, "hold");
    runCycles(4);
    total += 4;
    if (outCnt != 11) begin bad++; $display("[TB] FAIL hold_count: got %0d want 11", outCnt); end
    if (ch2EarlyCnt != 0) begin bad++; $display("[TB] FAIL hold_ch2_ready: got %0d early cycles want 0", ch2EarlyCnt); end
    if (outCycle[3] - outCycle[2] != 6) begin bad++; $display("[TB] FAIL hold_bubble: got %0d want 6", outCycle[3] - outCycle[2]); end
    if (outCycle[8] - outCycle[7] != 2) begin bad++; $display("[TB] FAIL hold_switch_gap: got %0d want 2", outCycle[8] - outCycle[7]); end
    for (int j = 0; j < 11 && j < outCnt; j++) begin
      expData = (j < 8) ? 32'h1100_0000 + j : 32'h2200_0000 + (j - 8);
      total++;
      if (outData[j] !== expData || outTid[j] !== ((j < 8) ? 2'd1 : 2'd2) || outLast[j] !== (j == 7 || j == 10)) begin
        bad++;
        $display("[TB] FAIL hold_beat%0d: got d=%h id=%0d l=%b, want d=%h id=%0d l=%b",
                 j, outData[j], outTid[j], outLast[j], expData, (j < 8) ? 1 : 2, (j == 7 || j == 10));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    applyReset();
    loadFrame(3, 10, 32'h3300_0000, 0);
    k = 0;
    while (outCnt < 3 && k < 20) begin
      runCycle();
      k++;
    end
    total++;
    if (outCnt < 3) begin bad++; $display("[TB] FAIL midrst_timeout: got %0d beats want 3", outCnt); end
    aresetn = 1'b0;
    #1;
    total += 5;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tvalid: got %b want 0", m_axis_tvalid); end
    if (m_axis_tdata !== '0) begin bad++; $display("[TB] FAIL midrst_tdata: got %h want 0", m_axis_tdata); end
    if (m_axis_tlast !== 1'b0 || m_axis_tid !== '0) begin bad++; $display("[TB] FAIL midrst_tlast_tid: got %b/%0d want 0/0", m_axis_tlast, m_axis_tid); end
    if (s_axis_tready !== '0) begin bad++; $display("[TB] FAIL midrst_s_tready: got %b want 0000", s_axis_tready); end
    if (trunc_pulse !== 1'b0) begin bad++; $display("[TB] FAIL midrst_trunc: got %b want 0", trunc_pulse); end
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    clearState();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    loadFrame(3, 2, 32'h3A00_0000, 0);
    loadFrame(0, 2, 32'h0A00_0000, 0);
    runUntil(4, 30, "midrst");
    runCycles(4);
    total += 2;
    if (outCnt != 4) begin bad++; $display("[TB] FAIL midrst_count: got %0d want 4", outCnt); end
    if (outTid[0] !== 2'd0 || outData[0] !== 32'h0A00_0000) begin
      bad++; $display("[TB] FAIL midrst_first: got id=%0d d=%h want id=0 d=0a000000", outTid[0], outData[0]);
    end
    total++;
    if (outTid[2] !== 2'd3 || outData[3] !== 32'h3A00_0001 || outLast[3] !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_second: got id=%0d d=%h l=%b want id=3 d=3a000001 l=1", outTid[2], outData[3], outLast[3]);
    end
  endtask

`ifdef ETH_TX_ARB_MAXLEN_EN
  task automatic test_truncation();
    logic [DATA_W-1:0] expData;
    applyReset();
    loadFrame(1, 10, 32'h6100_0000, 0);
    loadFrame(1, 3, 32'h6200_0000, 0);
    runUntil(11, 100, "trunc");
    runCycles(4);
    total += 3;
    if (outCnt != 11) begin bad++; $display("[TB] FAIL trunc_count: got %0d want 11", outCnt); end
    if (truncCnt != 1) begin bad++; $display("[TB] FAIL trunc_pulse: got %0d pulses want 1", truncCnt); end
    if (srcPos[1] != 13) begin bad++; $display("[TB] FAIL trunc_drop: got %0d accepted want 13", srcPos[1]); end
    for (int j = 0; j < 11 && j < outCnt; j++) begin
      expData = (j < 8) ? 32'h6100_0000 + j : 32'h6200_0000 + (j - 8);
      total++;
      if (outData[j] !== expData || outTid[j] !== 2'd1 || outLast[j] !== (j == 7 || j == 10)) begin
        bad++;
        $display("[TB] FAIL trunc_beat%0d: got d=%h id=%0d l=%b, want d=%h id=1 l=%b",
                 j, outData[j], outTid[j], outLast[j], expData, (j == 7 || j == 10));
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    accepted = '0;
    prevData = '0;
    prevLast = 1'b0;
    prevTid = '0;
    test_reset();
    test_single_frame();
    test_all_channels();
    test_random_stall();
    test_hold_grant();
    test_reset_mid_frame();
`ifdef ETH_TX_ARB_MAXLEN_EN
    test_truncation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
